// File: rtl/fifo_rr_drain_sched.sv
// ---------------------------------------------------------------------------
// fifo_rr_drain_sched
//
// Round-robin read scheduler. It drains a bank of first-word-fall-through
// shallow FIFOs into a single valid/ready stream. Each grant allows a burst
// of up to BURST_LEN words. The grant then rotates to the next eligible
// channel after the one that was last served. A channel is eligible when it
// is unmasked and its FIFO is non-empty.
//
// Optional feature (macro FIFO_SCHED_URGENT_EN):
//   When the macro is defined, an eligible channel that reports prog_full
//   wins arbitration ahead of the round-robin order. The lowest such index
//   wins. Without the macro, fifo_prog_full is ignored.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   sched_en        gates the start of new bursts only
//   ch_mask         per-channel arbitration enable
//   fifo_empty      FIFO empty flags
//   fifo_prog_full  FIFO prog_full flags (urgent feature only)
//   fifo_rd_data    FWFT read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rd_en      one-hot pop strobe, combinational with the transfer
//   out_valid       output word valid
//   out_ready       downstream accept
//   out_data        output word
//   out_ch          source channel of out_data
//   out_last        final word of a full-length burst
//   busy            a burst is in progress
// ---------------------------------------------------------------------------
module fifo_rr_drain_sched #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CH_WIDTH   = $clog2(NUM_CH),
  parameter int BEAT_WIDTH = $clog2(BURST_LEN) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sched_en,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH-1:0]            fifo_prog_full,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_WIDTH-1:0]          out_ch,
  output logic                         out_last,
  output logic                         busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CH_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_WIDTH-1:0]   grant_idx_q, grant_idx_d;
  logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic [NUM_CH-1:0]     eligible;
  logic                  pick_found;
  logic [CH_WIDTH-1:0]   pick_idx;
  logic [CH_WIDTH-1:0]   cand;
  logic                  last_beat;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  assign eligible  = ch_mask & ~fifo_empty;
  assign last_beat = (beat_cnt_q == BEAT_WIDTH'(BURST_LEN - 1));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data[i] = fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_SCHED_URGENT_EN
  logic [NUM_CH-1:0] urgent;
  assign urgent = eligible & fifo_prog_full;
`else
  logic unused_prog_full;
  assign unused_prog_full = ^fifo_prog_full;
`endif

  // The scan starts one past the last served channel and wraps modulo
  // NUM_CH. That way a lone eligible channel is still found, because its
  // own index is the last candidate tried.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      cand = CH_WIDTH'((int'(rr_ptr_q) + off) % NUM_CH);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
`ifdef FIFO_SCHED_URGENT_EN
    // An urgent channel overrides the rotation. The loop runs downward so
    // the lowest urgent index is the one that remains.
    if (|urgent) begin
      pick_found = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (urgent[i]) begin
          pick_idx = CH_WIDTH'(i);
        end
      end
    end
`endif
  end

  // Next-state and output decode. out_valid comes straight from the granted
  // FIFO's empty flag. The FIFO only loses words when we pop it, so a
  // presented word stays put until it is accepted. A granted FIFO that is
  // already empty ends the burst early.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;
    xfer        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sched_en && pick_found) begin
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        busy      = 1'b1;
        out_valid = ~fifo_empty[grant_idx_q];
        out_last  = out_valid & last_beat;
        xfer      = out_valid & out_ready;
        if (xfer) begin
          if (last_beat) begin
            state_d    = IDLE;
            rr_ptr_d   = grant_idx_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (!out_valid) begin
          state_d  = IDLE;
          rr_ptr_d = grant_idx_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The pop strobe is combinational with the handshake. The word that is
  // accepted this cycle leaves the FIFO on the same clock edge.
  always_comb begin
    fifo_rd_en = '0;
    if (xfer) begin
      fifo_rd_en[grant_idx_q] = 1'b1;
    end
  end

  assign out_data = ch_data[grant_idx_q];
  assign out_ch   = grant_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= CH_WIDTH'(NUM_CH - 1);
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// ---------------------------------------------------------------------------
// tb_fifo_rr_drain_sched
//
// Self-checking bench for fifo_rr_drain_sched.
//
// The channel FIFOs are modelled as queues. A transaction-level scheduler
// model (owner, words sent, last served channel) predicts every output on
// each falling edge. Directed scenarios pin the model with literal
// expectations. A randomized phase then mixes pushes, masks, backpressure
// and resets.
//
// The bench honours FIFO_SCHED_URGENT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fifo_rr_drain_sched;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int BL     = 4;
  localparam int CHW    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sched_en = 1'b0;
  logic [NUM_CH-1:0]    ch_mask = '0;
  logic [NUM_CH-1:0]    fifo_empty = '1;
  logic [NUM_CH-1:0]    fifo_prog_full = '0;
  logic [NUM_CH*DW-1:0] fifo_rd_data = '0;
  logic [NUM_CH-1:0]    fifo_rd_en;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DW-1:0]        out_data;
  logic [CHW-1:0]       out_ch;
  logic                 out_last;
  logic                 busy;

  fifo_rr_drain_sched #(
    .NUM_CH    (NUM_CH),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sched_en      (sched_en),
    .ch_mask       (ch_mask),
    .fifo_empty    (fifo_empty),
    .fifo_prog_full(fifo_prog_full),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ch        (out_ch),
    .out_last      (out_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // FIFO contents and scheduler model state
  logic [DW-1:0] fq [NUM_CH][$];
  int  mBusy = 0;
  int  mOwner = 0;
  int  mCount = 0;
  int  mPtr = NUM_CH - 1;
  int  pendingPop = -1;
  int  randomMode = 0;
  int  cycleNum = 0;
  int  rd0Count = 0;
  int  nVectors = 0;
  int  nMiscompares = 0;

  // Log of transfers observed at the DUT output
  logic [DW-1:0] logData [$];
  int            logCh [$];
  int            logLast [$];
  int            logCyc [$];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNum);
    end
  endtask

  function automatic void driveFifos();
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_rd_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : DW'($urandom);
    end
  endfunction

  function automatic void clearLogs();
    logData.delete();
    logCh.delete();
    logLast.delete();
    logCyc.delete();
    rd0Count = 0;
  endfunction

  // Next grant by the arbitration rules. Urgent channels win first when the
  // feature is built in. Otherwise the first eligible channel after the
  // last served one, wrapping around, gets the grant.
  function automatic int pickNext();
    int pick;
    pick = -1;
`ifdef FIFO_SCHED_URGENT_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i] && fq[i].size() != 0 && fifo_prog_full[i]) pick = i;
    end
    if (pick >= 0) return pick;
`endif
    for (int off = 1; off <= NUM_CH; off++) begin
      int c;
      c = (mPtr + off) % NUM_CH;
      if (ch_mask[c] && fq[c].size() != 0) return c;
    end
    return -1;
  endfunction

  // Compare process. On each falling edge it checks the outputs against the
  // model, logs what the DUT handed over, and then advances the model.
  always @(negedge clk) begin
    logic          expValid;
    logic [NUM_CH-1:0] expRdEn;
    int            g;
    cycleNum++;
    if (!rst_n) begin
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
      mBusy = 0; mOwner = 0; mCount = 0; mPtr = NUM_CH - 1; pendingPop = -1;
    end else begin
      expValid = (mBusy != 0) && (fq[mOwner].size() != 0);
      expRdEn = '0;
      if (expValid && out_ready) expRdEn[mOwner] = 1'b1;
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("out_valid", 32'(out_valid), 32'(expValid));
      checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(expRdEn));
      checkOutput("out_last", 32'(out_last), 32'(expValid && mCount == BL - 1));
      if (expValid) begin
        checkOutput("out_data", 32'(out_data), 32'(fq[mOwner][0]));
        checkOutput("out_ch", 32'(out_ch), 32'(mOwner));
      end
      if (out_valid && out_ready) begin
        logData.push_back(out_data);
        logCh.push_back(int'(out_ch));
        logLast.push_back(int'(out_last));
        logCyc.push_back(cycleNum);
      end
      if (fifo_rd_en[0]) rd0Count++;
      pendingPop = -1;
      if (mBusy == 0) begin
        if (sched_en) begin
          g = pickNext();
          if (g >= 0) begin
            mBusy = 1; mOwner = g; mCount = 0;
          end
        end
      end else if (!expValid) begin
        mBusy = 0; mPtr = mOwner;
      end else if (out_ready) begin
        pendingPop = mOwner;
        mCount++;
        if (mCount == BL) begin
          mBusy = 0; mPtr = mOwner;
        end
      end
    end
  end

  // One clock of stimulus. It applies the model's pop, adds random traffic
  // when enabled, and re-drives the FIFO flags and data.
  task automatic applyStimulus();
    logic [DW-1:0] tmp;
    @(posedge clk);
    #1;
    if (pendingPop >= 0 && fq[pendingPop].size() != 0) tmp = fq[pendingPop].pop_front();
    pendingPop = -1;
    if (randomMode != 0) begin
      out_ready = ($urandom_range(0, 3) != 0);
      sched_en  = ($urandom_range(0, 7) != 0);
      ch_mask   = ($urandom_range(0, 1) != 0) ? '1 : NUM_CH'($urandom_range(0, 15));
      for (int i = 0; i < NUM_CH; i++) begin
        if (fq[i].size() < 6 && $urandom_range(0, 2) == 0) fq[i].push_back(DW'($urandom));
        fifo_prog_full[i] = (fq[i].size() >= 4);
      end
    end
    driveFifos();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    randomMode = 0;
    out_ready = 1'b1;
    sched_en = 1'b1;
    ch_mask = '1;
    fifo_prog_full = '0;
    for (int i = 0; i < NUM_CH; i++) fq[i].delete();
    driveFifos();
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    clearLogs();
  endtask

  task automatic fillAll(input int depth);
    for (int i = 0; i < NUM_CH; i++)
      for (int j = 0; j < depth; j++) fq[i].push_back(DW'(i * 16 + j));
    driveFifos();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants[$];
    int exp2[8];
    int ok;
    exp2 = '{0, 1, 2, 3, 0, 1, 2, 3};

    // t1: one channel with 10 words drains as bursts of 4, 4 and 2
    doReset();
    for (int k = 0; k < 10; k++) fq[0].push_back(DW'(8'hA0 + k));
    driveFifos();
    repeat (30) applyStimulus();
    checkOutput("t1_words", 32'(logData.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < logData.size()) begin
        checkOutput("t1_data", 32'(logData[k]), 32'(8'hA0 + k));
        checkOutput("t1_last", 32'(logLast[k]), 32'((k == 3 || k == 7) ? 1 : 0));
      end
    end
    if (logCyc.size() >= 9) begin
      checkOutput("t1_gap1", 32'(logCyc[4] - logCyc[3]), 32'd2);
      checkOutput("t1_gap2", 32'(logCyc[8] - logCyc[7]), 32'd2);
    end
    checkOutput("t1_rd_en0_pulses", 32'(rd0Count), 32'd10);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);

    // t2: all channels loaded, grants rotate 0..3 twice
    doReset();
    fillAll(8);
    repeat (60) applyStimulus();
    checkOutput("t2_words", 32'(logData.size()), 32'd32);
    grants.delete();
    for (int k = 0; k < logCh.size(); k++) begin
      if (k == 0 || logCh[k] != logCh[k-1]) grants.push_back(logCh[k]);
      checkOutput("t2_src", 32'(logData[k][7:4]), 32'(logCh[k]));
    end
    checkOutput("t2_grant_count", 32'(grants.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < grants.size()) checkOutput("t2_grant_order", 32'(grants[k]), 32'(exp2[k]));

    // t3: backpressure pattern 1,0,0,1 inside a burst
    doReset();
    for (int k = 0; k < 4; k++) fq[2].push_back(DW'(8'h20 + k));
    driveFifos();
    begin
      int pat[6];
      pat = '{1, 0, 0, 1, 1, 1};
      for (int p = 0; p < 6; p++) begin
        applyStimulus();
        out_ready = pat[p][0];
        if (p == 1) checkOutput("t3_busy_stalled", 32'(busy), 32'd1);
      end
    end
    out_ready = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("t3_words", 32'(logData.size()), 32'd4);
    if (logData.size() == 4) begin
      checkOutput("t3_stall_span", 32'(logCyc[1] - logCyc[0]), 32'd3);
      checkOutput("t3_data1", 32'(logData[1]), 32'h21);
      checkOutput("t3_last3", 32'(logLast[3]), 32'd1);
      checkOutput("t3_last2", 32'(logLast[2]), 32'd0);
    end

    // t4: mask 1010 alternates ch1/ch3; dropping sched_en lets the burst finish
    doReset();
    ch_mask = 4'b1010;
    fillAll(8);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus();
      if (logData.size() >= 6) begin ok = 1; break; end
    end
    checkOutput("t4_reach_6_words", 32'(ok), 32'd1);
    sched_en = 1'b0;
    repeat (15) applyStimulus();
    checkOutput("t4_words", 32'(logData.size()), 32'd8);
    for (int k = 0; k < logCh.size(); k++)
      checkOutput("t4_grant", 32'(logCh[k]), 32'((k < 4) ? 1 : 3));
    checkOutput("t4_busy_held_low", 32'(busy), 32'd0);

    // t5: reset on the 2nd beat of a burst, then restart from ch0
    doReset();
    fillAll(8);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      applyStimulus();
      if (logData.size() >= 5) begin ok = 1; break; end
    end
    checkOutput("t5_reach_beat", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_valid_in_reset", 32'(out_valid), 32'd0);
    checkOutput("t5_rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
    checkOutput("t5_busy_in_reset", 32'(busy), 32'd0);
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    clearLogs();
    repeat (12) applyStimulus();
    if (logData.size() > 0) begin
      checkOutput("t5_restart_ch", 32'(logCh[0]), 32'd0);
      checkOutput("t5_restart_data", 32'(logData[0]), 32'h04);
    end else begin
      checkOutput("t5_restart_words", 32'd0, 32'd1);
    end

    // t6: rr_ptr at ch0, prog_full on ch3 (urgent feature decides the winner)
    doReset();
    fq[0].push_back(8'h5A);
    driveFifos();
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (busy) begin ok = 1; break; end
    end
    checkOutput("t6_ch0_busy", 32'(ok), 32'd1);
    for (int i = 1; i < NUM_CH; i++) begin
      fq[i].push_back(DW'(i * 16));
      fq[i].push_back(DW'(i * 16 + 1));
    end
    fifo_prog_full = 4'b1000;
    driveFifos();
    repeat (10) applyStimulus();
    if (logCh.size() >= 2) begin
      checkOutput("t6_first_ch0", 32'(logCh[0]), 32'd0);
`ifdef FIFO_SCHED_URGENT_EN
      checkOutput("t6_next_grant", 32'(logCh[1]), 32'd3);
`else
      checkOutput("t6_next_grant", 32'(logCh[1]), 32'd1);
`endif
    end else begin
      checkOutput("t6_words", 32'(logCh.size()), 32'd2);
    end

    // Randomized phase checked by the model alone
    doReset();
    randomMode = 1;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
      end
    end
    randomMode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
